fetch_queue: RTL

Instruction prefetch stage directly upstream of the core's decode/register-read pipeline register. It generates sequential instruction-memory addresses, buffers returned words with their PCs in a small FIFO, and presents one instruction per cycle to decode under a valid/ready handshake. On a taken branch or jump from execute (`originPc`/`pcBranch`), it flushes all buffered and in-flight words and restarts at the branch target.

---
 rtl/fewcore_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
// -----------------------------------------------------------------------------
// fewcore_pkg
// Shared types and constants for the fewcore front end.
//   INST_W           : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fq_state_e       : fetch-queue control FSM states
//   fq_entry_t       : one buffered fetch entry {inst, pc}
// -----------------------------------------------------------------------------
package fewcore_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FQ_BOOT,
        FQ_RUN,
        FQ_FULL,
        FQ_REDIRECT
    } fq_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the fetch queue's instruction-memory port, its decode-side
// valid/ready port and the redirect request from execute.
//   originPc        : redirect request from execute
//   pcBranch        : redirect target (word aligned)
//   imemAddress     : instruction-memory read address
//   imemReadEnabled : read request this cycle
//   imemData        : read data, one cycle after an accepted request
//   outValid        : head instruction available to decode
//   outInst/outPc   : head instruction word and its PC
//   outReady        : decode accepts the head this cycle
// Modports: master = fetch queue side, slave = memory/decode/execute side.
// -----------------------------------------------------------------------------
interface fetch_queue_if;
    import fewcore_pkg::*;

    logic              originPc;
    logic [31:0]       pcBranch;
    logic [31:0]       imemAddress;
    logic              imemReadEnabled;
    logic [INST_W-1:0] imemData;
    logic              outValid;
    logic [INST_W-1:0] outInst;
    logic [31:0]       outPc;
    logic              outReady;

    modport master (
        input  originPc, pcBranch, imemData, outReady,
        output imemAddress, imemReadEnabled, outValid, outInst, outPc
    );

    modport slave (
        output originPc, pcBranch, imemData, outReady,
        input  imemAddress, imemReadEnabled, outValid, outInst, outPc
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch entries with flush.
//   clk     : clock
//   reset   : synchronous, active-low
//   i_flush : empty the FIFO at the next edge (dominates push/pop)
//   i_push  : write i_data at the tail
//   i_data  : entry to write
//   i_pop   : remove the head entry
//   o_head  : head entry (contents undefined while empty)
//   o_count : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fewcore_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fq_entry_t                    i_data,
    input  logic                         i_pop,
    output fq_entry_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define what is
    // valid, and the top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch stage: issues sequential instruction-memory reads,
// buffers returned words with their PCs and hands them to decode under a
// valid/ready handshake. A redirect from execute flushes everything buffered
// or in flight and restarts fetch at the branch target.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : fetch_queue_if.master (imem port, decode port, redirect)
// Parameters: DEPTH (FIFO entries, power of two, >= 2), RESET_PC.
// Optional macro FETCHQ_BYPASS_EN: a response arriving while the FIFO is
// empty is presented to decode the same cycle, and is not written if taken.
// -----------------------------------------------------------------------------
module fetch_queue
    import fewcore_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            SW      = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    fq_state_e     r_state;
    fq_state_e     w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic          r_stale;

    logic          w_req;
    logic          w_resp_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;
    logic [CW-1:0] w_count;
    logic [SW-1:0] w_sum;
    logic [SW-1:0] w_sum_next;
    fq_entry_t     w_resp;
    fq_entry_t     w_fifo_head;
    fq_entry_t     w_head;

    assign w_resp       = '{inst: bus.imemData, pc: r_inflight_pc};
    assign w_resp_valid = r_inflight && !r_stale;

    // Credit uses registered occupancy only: a pop this cycle frees a slot
    // for the next cycle's request, not this one.
    assign w_sum      = SW'(w_count) + SW'(r_inflight);
    assign w_sum_next = SW'(w_count) + SW'(w_push) - SW'(w_pop) + SW'(w_req);

    // ---------------------------------------------------------------- FIFO
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (bus.originPc),
        .i_push  (w_push),
        .i_data  (w_resp),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_count)
    );

    // ------------------------------------------------- decode-side handshake
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_push       = w_resp_valid && !bus.originPc;
        w_head       = w_fifo_head;
        w_head_valid = (w_count != '0);
`ifdef FETCHQ_BYPASS_EN
        if ((w_count == '0) && w_resp_valid) begin
            w_head       = w_resp;
            w_head_valid = 1'b1;
            // Taken straight from the memory port: nothing to write.
            if (bus.outReady && !bus.originPc) w_push = 1'b0;
        end
`endif
        bus.outValid = w_head_valid && !bus.originPc;
        bus.outInst  = w_head_valid ? w_head.inst : '0;
        bus.outPc    = w_head_valid ? w_head.pc   : '0;
        // A bypassed word is never in the FIFO, so only count!=0 pops it.
        w_pop        = bus.outValid && bus.outReady && (w_count != '0);
    end

    // ------------------------------------------------ FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= FQ_BOOT;
        else        r_state <= w_state_next;
    end

    // ------------------------------------------------ FSM: next state
    // FULL is entered exactly when next cycle's registered occupancy plus
    // in-flight reaches DEPTH, so the state always matches the credit rule.
    always_comb begin
        w_state_next = r_state;
        if (bus.originPc) begin
            w_state_next = FQ_REDIRECT;
        end else if (r_state == FQ_BOOT) begin
            w_state_next = FQ_RUN;
        end else if (w_sum_next == DEPTH_S) begin
            w_state_next = FQ_FULL;
        end else begin
            w_state_next = FQ_RUN;
        end
    end

    // ------------------------------------------------ FSM: outputs
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            FQ_RUN:      w_req = (w_sum < DEPTH_S);
            FQ_REDIRECT: w_req = 1'b1;
            default:     w_req = 1'b0;
        endcase
        bus.imemReadEnabled = w_req;
        bus.imemAddress     = r_pc;
    end

    // ------------------------------------------- PC and in-flight tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_stale       <= 1'b0;
        end else begin
            r_inflight <= w_req;
            // A read issued in the redirect cycle belongs to the old path.
            r_stale    <= w_req && bus.originPc;
            if (w_req) r_inflight_pc <= r_pc;
            if (bus.originPc)  r_pc <= bus.pcBranch;
            else if (w_req)    r_pc <= r_pc + 32'd4;
        end
    end

endmodule
